// File: rtl/cordic_sincos_seq_if.sv
// Phase-in / cos-sin-out handshake bundle for the cordic sin/cos sequencer.
interface cordic_sincos_seq_if #(
  parameter int PHASE_W = 16,
  parameter int XY_W    = 17
) ();
  logic                      in_valid;
  logic                      in_ready;
  logic        [PHASE_W-1:0] phase_i;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [XY_W-1:0]    cos_o;
  logic signed [XY_W-1:0]    sin_o;
  logic        [1:0]         quad_o;

  modport slave  (input  in_valid, phase_i, out_ready,
                  output in_ready, out_valid, cos_o, sin_o, quad_o);
  modport master (output in_valid, phase_i, out_ready,
                  input  in_ready, out_valid, cos_o, sin_o, quad_o);
endinterface

// File: rtl/cordic_sincos_seq.sv
// Folds a binary phase to the first quadrant, drives an iterative cordic rotator,
// then unfolds the rotator result into full-circle signed cos/sin.
module cordic_sincos_seq #(
  parameter int PHASE_W    = 16,
  parameter int XY_W       = 17,
  parameter int TH_W       = 17,
  parameter int ITERATIONS = 16,
  parameter int CORDIC_ONE = 19899,
  parameter int HALF_PI    = 51472
) (
  input  logic                   clk,
  input  logic                   rst,
  cordic_sincos_seq_if.slave     io,
  output logic                   cordic_init,
  output logic signed [XY_W-1:0] cordic_x,
  output logic signed [XY_W-1:0] cordic_y,
  output logic        [TH_W-1:0] cordic_theta,
  input  logic signed [XY_W-1:0] cordic_x_o,
  input  logic signed [XY_W-1:0] cordic_y_o,
  output logic                   busy
);
  localparam int R_W    = PHASE_W - 2;
  localparam int PROD_W = R_W + TH_W;
  localparam int CNT_W  = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic signed [XY_W-1:0] x_q, x_d, y_q, y_d;
  logic [TH_W-1:0]        theta_q, theta_d;
  logic [1:0]             quad_q, quad_d;
  logic signed [XY_W-1:0] cos_q, cos_d, sin_q, sin_d;
  logic                   oval_q, oval_d;

  logic [PROD_W-1:0]      prod;
  logic [TH_W-1:0]        theta_new;
  logic signed [XY_W-1:0] ucos, usin;

  // In-quadrant remainder scaled to radians: r * (pi/2) / 2^R_W, truncated.
  assign prod      = PROD_W'(io.phase_i[R_W-1:0]) * PROD_W'(HALF_PI);
  assign theta_new = TH_W'(prod >> R_W);

  always_comb begin
    ucos = cordic_x_o;
    usin = cordic_y_o;
    unique case (quad_q)
      2'd0: begin ucos = cordic_x_o;  usin = cordic_y_o;  end
      2'd1: begin ucos = -cordic_y_o; usin = cordic_x_o;  end
      2'd2: begin ucos = -cordic_x_o; usin = -cordic_y_o; end
      default: begin ucos = cordic_y_o; usin = -cordic_x_o; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    theta_d = theta_q;
    quad_d  = quad_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    oval_d  = oval_q;
    unique case (state_q)
      IDLE: if (io.in_valid) begin
        quad_d  = io.phase_i[PHASE_W-1:PHASE_W-2];
        x_d     = XY_W'(CORDIC_ONE);
        y_d     = '0;
        theta_d = theta_new;
        state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = CNT_W'(ITERATIONS - 1);
        state_d = RUN;
      end
      RUN: if (cnt_q == '0) begin
        cos_d   = ucos;
        sin_d   = usin;
        oval_d  = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      default: if (io.out_ready) begin
        oval_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      theta_q <= '0;
      quad_q  <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      oval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      theta_q <= theta_d;
      quad_q  <= quad_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      oval_q  <= oval_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = oval_q;
  assign io.cos_o     = cos_q;
  assign io.sin_o     = sin_q;
  assign io.quad_o    = quad_q;
  assign cordic_init  = (state_q == LOAD);
  assign cordic_x     = x_q;
  assign cordic_y     = y_q;
  assign cordic_theta = theta_q;
  assign busy         = (state_q != IDLE);
endmodule
